// File: rtl/max7219_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : max7219_chain_ctrl                                         |
// | Description : Serial driver for a daisy chain of MAX7219 LED drivers,    |
// |               with boot/refresh configuration and dirty-row updates.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module max7219_chain_ctrl #(
    parameter int          N_DEV     = 1,
    parameter int          CLK_DIV   = 25,
    parameter logic [3:0]  INTENSITY = 4'hF,
    parameter logic [7:0]  DECODE    = 8'hFF,
    parameter int          CS_GAP    = 4,
    localparam int         DEV_W     = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [DEV_W-1:0] wr_dev,
    input  logic [2:0]       wr_digit,
    input  logic [7:0]       wr_data,
    input  logic             refresh,
    output logic             busy,
    output logic             init_done,
    output logic             spi_clk,
    output logic             spi_dout,
    output logic             spi_cs
);

    localparam int              c_frame_bits = 16 * N_DEV;
    localparam logic [15:0]     c_div_last   = 16'(CLK_DIV - 1);
    localparam logic [15:0]     c_gap_last   = 16'(CS_GAP * 2 * CLK_DIV - 1);
    localparam logic [7:0]      c_bit_last   = 8'(c_frame_bits - 1);
    localparam logic [DEV_W:0]  c_n_dev      = (DEV_W + 1)'(N_DEV);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_hold  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [7:0]              r_buf [N_DEV][8];
    logic [7:0]              r_dirty;
    logic                    r_init_pend;
    logic [2:0]              r_init_idx;
    logic                    r_cfg_done;
    logic                    r_init_done;
    logic                    r_run;
    logic [c_frame_bits-1:0] r_shift;
    logic [15:0]             r_div_cnt;
    logic [7:0]              r_bit_cnt;
    logic                    r_spi_clk;
    logic                    r_spi_cs;
    logic                    r_spi_dout;

    logic                    w_wr_ok;
    logic [7:0]              w_wr_mask;
    logic [7:0]              w_dirty_clr;
    logic [7:0]              w_dirty_next;
    logic                    w_div_done;
    logic                    w_gap_done;
    logic                    w_last_bit;
    logic [2:0]              w_row;
    logic [7:0]              w_row_addr;
    logic [15:0]             w_init_word;
    logic [c_frame_bits-1:0] w_frame;

    assign w_wr_ok    = wr_en && ({1'b0, wr_dev} < c_n_dev);
    assign w_wr_mask  = w_wr_ok ? (8'b1 << wr_digit) : 8'h00;
    assign w_div_done = (r_div_cnt == c_div_last);
    assign w_gap_done = (r_div_cnt == c_gap_last);
    assign w_last_bit = (r_bit_cnt == c_bit_last);
    assign w_row_addr = {5'd0, w_row} + 8'd1;

    // A same-cycle write re-arms the row being loaded; refresh re-arms all rows.
    assign w_dirty_clr  = (r_state == c_st_load && !r_init_pend) ? (8'b1 << w_row) : 8'h00;
    assign w_dirty_next = refresh ? 8'hFF : ((r_dirty & ~w_dirty_clr) | w_wr_mask);

    always_comb begin
        w_row = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_dirty[i]) w_row = 3'(i);
        end
    end

    always_comb begin
        case (r_init_idx)
            3'd0:    w_init_word = 16'h0F00;
            3'd1:    w_init_word = 16'h0C01;
            3'd2:    w_init_word = 16'h0B07;
            3'd3:    w_init_word = {8'h0A, 4'h0, INTENSITY};
            default: w_init_word = {8'h09, DECODE};
        endcase
    end

    // Device 0 occupies the low word so it is shifted out last.
    always_comb begin
        w_frame = '0;
        for (int dev = 0; dev < N_DEV; dev++) begin
            w_frame[16*dev +: 16] = r_init_pend ? w_init_word : {w_row_addr, r_buf[dev][w_row]};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (r_init_pend || (r_dirty != 8'h00)) w_state_next = c_st_load;
            c_st_load:  w_state_next = c_st_shift;
            c_st_shift: if (w_div_done && r_spi_clk && w_last_bit) w_state_next = c_st_hold;
            c_st_hold:  if (w_div_done) w_state_next = c_st_gap;
            c_st_gap:   if (w_gap_done) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < N_DEV; d++) begin
                for (int r = 0; r < 8; r++) r_buf[d][r] <= 8'h00;
            end
            r_dirty     <= 8'hFF;
            r_init_pend <= 1'b1;
            r_init_idx  <= 3'd0;
            r_cfg_done  <= 1'b0;
            r_init_done <= 1'b0;
            r_run       <= 1'b0;
            r_shift     <= '0;
            r_div_cnt   <= 16'd0;
            r_bit_cnt   <= 8'd0;
            r_spi_clk   <= 1'b0;
            r_spi_cs    <= 1'b1;
            r_spi_dout  <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_dirty <= w_dirty_next;
            if (w_wr_ok) r_buf[wr_dev][wr_digit] <= wr_data;

            if (refresh) begin
                r_init_pend <= 1'b1;
                r_init_idx  <= 3'd0;
            end else if (r_state == c_st_load && r_init_pend) begin
                if (r_init_idx == 3'd4) begin
                    r_init_pend <= 1'b0;
                    r_init_idx  <= 3'd0;
                    r_cfg_done  <= 1'b1;
                end else begin
                    r_init_idx <= r_init_idx + 3'd1;
                end
            end

            case (r_state)
                c_st_load: begin
                    r_shift    <= w_frame;
                    r_spi_dout <= w_frame[c_frame_bits-1];
                    r_spi_cs   <= 1'b0;
                    r_spi_clk  <= 1'b0;
                    r_div_cnt  <= 16'd0;
                    r_bit_cnt  <= 8'd0;
                end
                c_st_shift: begin
                    if (w_div_done) begin
                        r_div_cnt <= 16'd0;
                        if (!r_spi_clk) begin
                            r_spi_clk <= 1'b1;
                        end else begin
                            r_spi_clk <= 1'b0;
                            if (!w_last_bit) begin
                                r_bit_cnt  <= r_bit_cnt + 8'd1;
                                r_shift    <= r_shift << 1;
                                r_spi_dout <= r_shift[c_frame_bits-2];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                c_st_hold: begin
                    if (w_div_done) begin
                        r_div_cnt  <= 16'd0;
                        r_spi_cs   <= 1'b1;
                        r_spi_dout <= 1'b0;
                        // LOAD edge of the final pending row after configuration.
                        if (r_cfg_done && !r_init_pend && !refresh && (w_dirty_next == 8'h00))
                            r_init_done <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                c_st_gap: begin
                    if (w_gap_done) r_div_cnt <= 16'd0;
                    else            r_div_cnt <= r_div_cnt + 16'd1;
                end
                default: r_div_cnt <= 16'd0;
            endcase
        end
    end

    assign busy      = r_run && ((r_state != c_st_idle) || r_init_pend || (r_dirty != 8'h00));
    assign init_done = r_init_done;
    assign spi_clk   = r_spi_clk;
    assign spi_dout  = r_spi_dout;
    assign spi_cs    = r_spi_cs;

endmodule
`default_nettype wire

// File: tb/tb_max7219_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_max7219_chain_ctrl                                      |
// | Description : Directed bench for max7219_chain_ctrl with 1, 2 and 3      |
// |               device chains, decoding the serial stream into frames.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_max7219_chain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [3];
    logic       wr_en    [3];
    logic       refresh  [3];
    logic [2:0] wr_digit [3];
    logic [7:0] wr_data  [3];
    logic [0:0] wr_dev0;
    logic [0:0] wr_dev1;
    logic [1:0] wr_dev2;
    logic       busy [3];
    logic       idone[3];
    logic       sclk [3];
    logic       sdo  [3];
    logic       scs  [3];

    max7219_chain_ctrl #(.N_DEV(1), .CLK_DIV(2), .INTENSITY(4'hF), .DECODE(8'hFF), .CS_GAP(4)) dut0 (
        .clk(clk), .reset(rst[0]), .wr_en(wr_en[0]), .wr_dev(wr_dev0), .wr_digit(wr_digit[0]),
        .wr_data(wr_data[0]), .refresh(refresh[0]), .busy(busy[0]), .init_done(idone[0]),
        .spi_clk(sclk[0]), .spi_dout(sdo[0]), .spi_cs(scs[0]));

    max7219_chain_ctrl #(.N_DEV(2), .CLK_DIV(2), .INTENSITY(4'hF), .DECODE(8'hFF), .CS_GAP(4)) dut1 (
        .clk(clk), .reset(rst[1]), .wr_en(wr_en[1]), .wr_dev(wr_dev1), .wr_digit(wr_digit[1]),
        .wr_data(wr_data[1]), .refresh(refresh[1]), .busy(busy[1]), .init_done(idone[1]),
        .spi_clk(sclk[1]), .spi_dout(sdo[1]), .spi_cs(scs[1]));

    max7219_chain_ctrl #(.N_DEV(3), .CLK_DIV(2), .INTENSITY(4'hF), .DECODE(8'hFF), .CS_GAP(4)) dut2 (
        .clk(clk), .reset(rst[2]), .wr_en(wr_en[2]), .wr_dev(wr_dev2), .wr_digit(wr_digit[2]),
        .wr_data(wr_data[2]), .refresh(refresh[2]), .busy(busy[2]), .init_done(idone[2]),
        .spi_clk(sclk[2]), .spi_dout(sdo[2]), .spi_cs(scs[2]));

    logic [63:0] q_word [3][$];
    int          q_bits [3][$];
    int          rd [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Frame decoder: shift on spi_clk rise while selected, close frame on spi_cs rise.
    for (genvar k = 0; k < 3; k++) begin : g_mon
        logic        pclk = 1'b0;
        logic        pcs = 1'b1;
        logic [63:0] sh = '0;
        int          nb = 0;
        int          cyc = 0;
        int          last_rise = 0;
        int          rise_cyc = 0;
        bit          have_rise = 0;
        int          per_err = 0;
        int          gap_err = 0;
        always @(negedge clk) begin
            cyc++;
            if (!pclk && sclk[k] && !scs[k]) begin
                if (nb > 0 && (cyc - last_rise) != 4) per_err++;
                last_rise = cyc;
                sh = {sh[62:0], sdo[k]};
                nb++;
            end
            if (pcs && !scs[k] && have_rise && (cyc - rise_cyc) < 16) gap_err++;
            if (!pcs && scs[k]) begin
                q_word[k].push_back(sh);
                q_bits[k].push_back(nb);
                sh = '0;
                nb = 0;
                rise_cyc = cyc;
                have_rise = 1;
            end
            if (rst[k]) have_rise = 0;
            pclk = sclk[k];
            pcs = scs[k];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int k, input int dev, input int dig, input int dat);
        wr_en[k] = 1'b1;
        case (k)
            0:       wr_dev0 = dev[0:0];
            1:       wr_dev1 = dev[0:0];
            default: wr_dev2 = dev[1:0];
        endcase
        wr_digit[k] = dig[2:0];
        wr_data[k]  = dat[7:0];
        @(negedge clk);
        wr_en[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int n, input int budget);
        int t = 0;
        while (q_word[k].size() < rd[k] + n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("frames_arrived_dut%0d", k), 64'(q_word[k].size() >= rd[k] + n), 64'd1);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int t = 0;
        while (busy[k] !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("idle_dut%0d", k), 64'(busy[k]), 64'd0);
    endtask

    task automatic wait_cs_low(input int k, input int budget);
        int t = 0;
        while (scs[k] !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("cs_fell_dut%0d", k), 64'(scs[k]), 64'd0);
    endtask

    task automatic get_frame(input int k, output logic [63:0] w, output int b);
        if (rd[k] < q_word[k].size()) begin
            w = q_word[k][rd[k]];
            b = q_bits[k][rd[k]];
            rd[k]++;
        end else begin
            w = 'x;
            b = -1;
        end
    endtask

    task automatic flush(input int k);
        rd[k] = q_word[k].size();
    endtask

    logic [15:0] exp13 [13] = '{16'h0F00, 16'h0C01, 16'h0B07, 16'h0A0F, 16'h09FF,
                                16'h0100, 16'h0200, 16'h0300, 16'h0400,
                                16'h0500, 16'h0600, 16'h0700, 16'h0800};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] w;
        int          b;
        int          bsum;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; wr_en[k] = 1'b0; refresh[k] = 1'b0;
            wr_digit[k] = 3'd0; wr_data[k] = 8'h00; rd[k] = 0;
        end
        wr_dev0 = '0; wr_dev1 = '0; wr_dev2 = '0;
        repeat (4) @(negedge clk);

        chk("rst_spi_clk",   64'(sclk[0]),  64'd0);
        chk("rst_spi_cs",    64'(scs[0]),   64'd1);
        chk("rst_spi_dout",  64'(sdo[0]),   64'd0);
        chk("rst_busy",      64'(busy[0]),  64'd0);
        chk("rst_init_done", 64'(idone[0]), 64'd0);
        chk("rst_busy_dut2", 64'(busy[2]),  64'd0);

        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_release", 64'(busy[0]), 64'd1);

        // Boot sequence on a single device
        wait_frames(0, 12, 3000);
        chk("init_done_before_last_row", 64'(idone[0]), 64'd0);
        wait_frames(0, 13, 500);
        chk("init_done_after_last_row", 64'(idone[0]), 64'd1);
        for (int i = 0; i < 13; i++) begin
            get_frame(0, w, b);
            chk($sformatf("boot_word%0d", i), w, 64'(exp13[i]));
            chk($sformatf("boot_bits%0d", i), 64'(b), 64'd16);
        end
        wait_idle(0, 500);
        chk("init_done_idle", 64'(idone[0]), 64'd1);

        // Write landing on the LOAD cycle of the same row leaves it dirty
        flush(0);
        wr(0, 0, 2, 'h33);
        wr(0, 0, 2, 'h33);
        wr(0, 0, 2, 'h44);
        wait_frames(0, 2, 500);
        get_frame(0, w, b);
        chk("load_coincide_first", w, 64'h0333);
        get_frame(0, w, b);
        chk("load_coincide_resend", w, 64'h0344);
        wait_idle(0, 500);

        // Write during shifting of the same row
        flush(0);
        wr(0, 0, 0, 'h00);
        wait_cs_low(0, 100);
        repeat (10) @(negedge clk);
        wr(0, 0, 0, 'h12);
        wait_frames(0, 2, 500);
        get_frame(0, w, b);
        chk("shift_write_old", w, 64'h0100);
        get_frame(0, w, b);
        chk("shift_write_new", w, 64'h0112);
        wait_idle(0, 500);
        chk("shift_write_no_extra", 64'(q_word[0].size() - rd[0]), 64'd0);

        // Refresh after loading the whole buffer
        for (int i = 0; i < 8; i++) wr(0, 0, i, 'hA0 + i);
        wait_idle(0, 2000);
        flush(0);
        refresh[0] = 1'b1;
        @(negedge clk);
        refresh[0] = 1'b0;
        chk("refresh_busy", 64'(busy[0]), 64'd1);
        wait_frames(0, 13, 2000);
        for (int i = 0; i < 13; i++) begin
            get_frame(0, w, b);
            if (i < 5) chk($sformatf("refresh_cfg%0d", i), w, 64'(exp13[i]));
            else       chk($sformatf("refresh_row%0d", i - 5), w, 64'({8'(i - 4), 8'(8'hA0 + i - 5)}));
        end
        chk("refresh_init_done_kept", 64'(idone[0]), 64'd1);
        wait_idle(0, 500);

        // Reset in the middle of a frame
        wr(0, 0, 1, 'h55);
        wait_cs_low(0, 100);
        repeat (29) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("midrst_cs",   64'(scs[0]),  64'd1);
        chk("midrst_clk",  64'(sclk[0]), 64'd0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_init_done", 64'(idone[0]), 64'd0);
        repeat (2) @(negedge clk);
        flush(0);
        rst[0] = 1'b0;
        wait_frames(0, 13, 3000);
        for (int i = 0; i < 13; i++) begin
            get_frame(0, w, b);
            chk($sformatf("reboot_word%0d", i), w, 64'(exp13[i]));
        end

        // Two-device chain: broadcast config, then one combined row frame
        wait_frames(1, 13, 4000);
        get_frame(1, w, b);
        chk("dut1_cfg0_word", w, 64'h0F000F00);
        chk("dut1_cfg0_bits", 64'(b), 64'd32);
        rd[1] = rd[1] + 3;
        get_frame(1, w, b);
        chk("dut1_cfg4_word", w, 64'h09FF09FF);
        rd[1] = rd[1] + 7;
        get_frame(1, w, b);
        chk("dut1_row8_word", w, 64'h08000800);
        wait_idle(1, 1000);
        chk("dut1_init_done", 64'(idone[1]), 64'd1);
        flush(1);
        wr(1, 1, 3, 'h05);
        wr(1, 0, 3, 'h0A);
        wait_frames(1, 1, 1000);
        get_frame(1, w, b);
        chk("dut1_row3_word", w, 64'h0405040A);
        chk("dut1_row3_bits", 64'(b), 64'd32);
        wait_idle(1, 1000);
        chk("dut1_single_frame", 64'(q_word[1].size() - rd[1]), 64'd0);

        // Three-device chain: out-of-range device ignored, then a valid write
        wait_idle(2, 6000);
        chk("dut2_init_done", 64'(idone[2]), 64'd1);
        flush(2);
        wr(2, 3, 0, 'h77);
        bsum = 0;
        for (int i = 0; i < 30; i++) begin
            bsum += int'(busy[2]);
            @(negedge clk);
        end
        chk("dut2_bad_dev_busy", 64'(bsum), 64'd0);
        chk("dut2_bad_dev_frames", 64'(q_word[2].size() - rd[2]), 64'd0);
        wr(2, 2, 0, 'h77);
        wait_frames(2, 1, 1000);
        get_frame(2, w, b);
        chk("dut2_dev2_word", w, 64'h017701000100);
        chk("dut2_dev2_bits", 64'(b), 64'd48);
        wait_idle(2, 1000);

        chk("dut0_bit_period", 64'(g_mon[0].per_err), 64'd0);
        chk("dut1_bit_period", 64'(g_mon[1].per_err), 64'd0);
        chk("dut2_bit_period", 64'(g_mon[2].per_err), 64'd0);
        chk("dut0_cs_gap",     64'(g_mon[0].gap_err), 64'd0);
        chk("dut1_cs_gap",     64'(g_mon[1].gap_err), 64'd0);
        chk("dut2_cs_gap",     64'(g_mon[2].gap_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
